// File: rtl/eeg_wram_fetch_if.sv
// Handshake bundle between the WRAM fetch engine and its neighbours:
// command port, WRAM address/data channels and the downstream data port.
interface eeg_wram_fetch_if #(
    parameter int WRAM_ADD_AW  = 13,
    parameter int WRAM_DAT_DW  = 8,
    parameter int FETCH_LEN_DW = 13
);
    logic                    IS_IDLE;

    logic                    CFG_INFO_VLD;
    logic                    CFG_INFO_RDY;
    logic [WRAM_ADD_AW-1:0]  CFG_BASE_ADD;
    logic [WRAM_ADD_AW-1:0]  CFG_ADD_STP;
    logic [FETCH_LEN_DW-1:0] CFG_DAT_LEN;

    logic                    ETOW_ADD_VLD;
    logic                    ETOW_ADD_LST;
    logic                    ETOW_ADD_RDY;
    logic [WRAM_ADD_AW-1:0]  ETOW_ADD_ADD;

    logic                    WTOE_DAT_VLD;
    logic                    WTOE_DAT_LST;
    logic                    WTOE_DAT_RDY;
    logic [WRAM_DAT_DW-1:0]  WTOE_DAT_DAT;

    logic                    OUT_DAT_VLD;
    logic                    OUT_DAT_LST;
    logic                    OUT_DAT_RDY;
    logic [WRAM_DAT_DW-1:0]  OUT_DAT_DAT;

    // The fetch engine side.
    modport master (
        output IS_IDLE,
        input  CFG_INFO_VLD, CFG_BASE_ADD, CFG_ADD_STP, CFG_DAT_LEN,
        output CFG_INFO_RDY,
        output ETOW_ADD_VLD, ETOW_ADD_LST, ETOW_ADD_ADD,
        input  ETOW_ADD_RDY,
        input  WTOE_DAT_VLD, WTOE_DAT_LST, WTOE_DAT_DAT,
        output WTOE_DAT_RDY,
        output OUT_DAT_VLD, OUT_DAT_LST, OUT_DAT_DAT,
        input  OUT_DAT_RDY
    );

    // The environment: command source, WRAM bank and consumer.
    modport slave (
        input  IS_IDLE,
        output CFG_INFO_VLD, CFG_BASE_ADD, CFG_ADD_STP, CFG_DAT_LEN,
        input  CFG_INFO_RDY,
        input  ETOW_ADD_VLD, ETOW_ADD_LST, ETOW_ADD_ADD,
        output ETOW_ADD_RDY,
        output WTOE_DAT_VLD, WTOE_DAT_LST, WTOE_DAT_DAT,
        input  WTOE_DAT_RDY,
        input  OUT_DAT_VLD, OUT_DAT_LST, OUT_DAT_DAT,
        output OUT_DAT_RDY
    );
endinterface

// File: rtl/eeg_wram_fetch.sv
// WRAM read initiator: issues a strided address stream and returns the read
// words in order through a credit-protected FIFO so WTOE_DAT_RDY never stalls.
module eeg_wram_fetch #(
    parameter int WRAM_ADD_AW  = 13,
    parameter int WRAM_DAT_DW  = 8,
    parameter int FETCH_LEN_DW = 13,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    eeg_wram_fetch_if.master     bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [WRAM_ADD_AW-1:0]  addr_q, addr_d;
    logic [WRAM_ADD_AW-1:0]  step_q, step_d;
    logic [FETCH_LEN_DW-1:0] len_q, len_d;
    logic [FETCH_LEN_DW-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]        used_q, used_d;
    logic [CNT_W-1:0]        fill_q, fill_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [WRAM_DAT_DW:0]    mem_q [FIFO_DEPTH];
    logic [WRAM_DAT_DW:0]    mem_d [FIFO_DEPTH];

    logic                    cfg_rdy;
    logic                    cfg_fire;
    logic                    addr_vld;
    logic                    addr_lst;
    logic                    addr_fire;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic [WRAM_DAT_DW:0]    head;

    assign cfg_rdy    = (state_q == ST_IDLE);
    assign cfg_fire   = bus.CFG_INFO_VLD & cfg_rdy;

    // Credit gate: never request more words than the FIFO can hold.
    assign addr_vld   = (state_q == ST_FETCH) && (used_q < DEPTH_C);
    assign addr_lst   = (state_q == ST_FETCH) && (cnt_q == len_q);
    assign addr_fire  = addr_vld & bus.ETOW_ADD_RDY;

    assign fifo_full  = (fill_q == DEPTH_C);
    assign fifo_empty = (fill_q == '0);
    assign push       = bus.WTOE_DAT_VLD & ~fifo_full;
    assign pop        = ~fifo_empty & bus.OUT_DAT_RDY;
    assign head       = mem_q[rd_ptr_q];

    assign bus.IS_IDLE      = cfg_rdy;
    assign bus.CFG_INFO_RDY = cfg_rdy;
    assign bus.ETOW_ADD_VLD = addr_vld;
    assign bus.ETOW_ADD_LST = addr_lst;
    assign bus.ETOW_ADD_ADD = addr_q;
    assign bus.WTOE_DAT_RDY = ~fifo_full;
    assign bus.OUT_DAT_VLD  = ~fifo_empty;
    assign bus.OUT_DAT_LST  = head[WRAM_DAT_DW];
    assign bus.OUT_DAT_DAT  = head[WRAM_DAT_DW-1:0];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        step_d  = step_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_fire) begin
                    state_d = ST_FETCH;
                    addr_d  = bus.CFG_BASE_ADD;
                    step_d  = bus.CFG_ADD_STP;
                    len_d   = bus.CFG_DAT_LEN;
                    cnt_d   = '0;
                end
            end
            ST_FETCH: begin
                if (addr_fire) begin
                    addr_d = addr_q + step_q;
                    cnt_d  = cnt_q + 1'b1;
                    if (addr_lst) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && head[WRAM_DAT_DW]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outstanding requests plus buffered words; a pop returns one credit.
    always_comb begin
        used_d = used_q;
        case ({addr_fire, pop})
            2'b10:   used_d = used_q + 1'b1;
            2'b01:   used_d = used_q - 1'b1;
            default: used_d = used_q;
        endcase
    end

    always_comb begin
        fill_d   = fill_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {bus.WTOE_DAT_LST, bus.WTOE_DAT_DAT};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            step_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            used_q   <= '0;
            fill_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            step_q   <= step_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            used_q   <= used_d;
            fill_q   <= fill_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: tb/tb_eeg_wram_fetch.sv
// Scoreboard bench for eeg_wram_fetch: a WRAM responder with 1-cycle latency,
// queue-based address/output monitors and directed fetch commands.
module tb_eeg_wram_fetch;

    localparam int AW    = 13;
    localparam int DW    = 8;
    localparam int LW    = 13;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    eeg_wram_fetch_if #(.WRAM_ADD_AW(AW), .WRAM_DAT_DW(DW), .FETCH_LEN_DW(LW)) bus ();

    eeg_wram_fetch #(
        .WRAM_ADD_AW (AW),
        .WRAM_DAT_DW (DW),
        .FETCH_LEN_DW(LW),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW:0]   exp_addr_q [$];
    logic [DW:0]   exp_out_q  [$];
    logic [DW:0]   wram_pend  [$];
    logic [AW-1:0] addr_log   [$];

    int addr_cnt, out_cnt;
    int first_addr_edge, last_addr_edge;
    int first_out_edge, last_out_edge;
    int last_lst_edge;
    int accept_edge;
    logic [DW-1:0] last_out_dat;

    logic [AW-1:0] wrap_exp [4] = '{13'h1FFE, 13'h0001, 13'h0004, 13'h0007};

    function automatic logic [DW-1:0] wramData(input logic [AW-1:0] a);
        return a[7:0] ^ 8'hB5;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clearStats();
        addr_cnt        = 0;
        out_cnt         = 0;
        first_addr_edge = 0;
        last_addr_edge  = 0;
        first_out_edge  = 0;
        last_out_edge   = 0;
        addr_log.delete();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_is_idle"},  32'(bus.IS_IDLE),      32'd1);
        checkOutput({tag, "_cfg_rdy"},  32'(bus.CFG_INFO_RDY), 32'd1);
        checkOutput({tag, "_etow_vld"}, 32'(bus.ETOW_ADD_VLD), 32'd0);
        checkOutput({tag, "_etow_lst"}, 32'(bus.ETOW_ADD_LST), 32'd0);
        checkOutput({tag, "_etow_add"}, 32'(bus.ETOW_ADD_ADD), 32'd0);
        checkOutput({tag, "_wtoe_rdy"}, 32'(bus.WTOE_DAT_RDY), 32'd1);
        checkOutput({tag, "_out_vld"},  32'(bus.OUT_DAT_VLD),  32'd0);
        checkOutput({tag, "_out_lst"},  32'(bus.OUT_DAT_LST),  32'd0);
        checkOutput({tag, "_out_dat"},  32'(bus.OUT_DAT_DAT),  32'd0);
    endtask

    // Push expected addresses/words, then present the command until accepted.
    task automatic applyStimulus(input logic [AW-1:0] base, input logic [AW-1:0] step,
                                 input logic [LW-1:0] len, input bit keep_vld);
        logic [31:0]   full;
        logic [AW-1:0] a;
        bit            acc;
        bit            lst;
        for (int k = 0; k <= int'(len); k++) begin
            full = 32'(base) + 32'(k) * 32'(step);
            a    = full[AW-1:0];
            lst  = (k == int'(len));
            exp_addr_q.push_back({lst, a});
            exp_out_q.push_back({lst, wramData(a)});
        end
        bus.CFG_BASE_ADD = base;
        bus.CFG_ADD_STP  = step;
        bus.CFG_DAT_LEN  = len;
        bus.CFG_INFO_VLD = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 500 && !acc; i++) begin
            @(negedge clk);
            if (bus.CFG_INFO_RDY) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        checkOutput("cfg_accept", 32'(acc), 32'd1);
        accept_edge = cyc;
        if (!keep_vld) bus.CFG_INFO_VLD = 1'b0;
        if (acc) checkOutput("first_addr_vld", 32'(bus.ETOW_ADD_VLD), 32'd1);
    endtask

    task automatic waitIdle(output int idle_edge);
        bit got;
        got       = 1'b0;
        idle_edge = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.IS_IDLE) begin
                got       = 1'b1;
                idle_edge = cyc;
                break;
            end
        end
        checkOutput("idle_reached", 32'(got), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitors sample at the falling edge; a VLD&RDY seen here fires at edge cyc+1.
    initial begin
        logic [AW:0] ea;
        logic [DW:0] eo;
        forever begin
            @(negedge clk);
            if (rst_n && bus.ETOW_ADD_VLD && bus.ETOW_ADD_RDY) begin
                if (exp_addr_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_addr: got 0x%0h expected none", bus.ETOW_ADD_ADD);
                end else begin
                    ea = exp_addr_q.pop_front();
                    checkOutput("etow_add", 32'(bus.ETOW_ADD_ADD), 32'(ea[AW-1:0]));
                    checkOutput("etow_lst", 32'(bus.ETOW_ADD_LST), 32'(ea[AW]));
                end
                if (addr_cnt == 0) first_addr_edge = cyc + 1;
                last_addr_edge = cyc + 1;
                addr_cnt++;
                addr_log.push_back(bus.ETOW_ADD_ADD);
            end
            if (rst_n && bus.OUT_DAT_VLD && bus.OUT_DAT_RDY) begin
                if (exp_out_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_out: got 0x%0h expected none", bus.OUT_DAT_DAT);
                end else begin
                    eo = exp_out_q.pop_front();
                    checkOutput("out_dat", 32'(bus.OUT_DAT_DAT), 32'(eo[DW-1:0]));
                    checkOutput("out_lst", 32'(bus.OUT_DAT_LST), 32'(eo[DW]));
                end
                if (out_cnt == 0) first_out_edge = cyc + 1;
                last_out_edge = cyc + 1;
                out_cnt++;
                last_out_dat = bus.OUT_DAT_DAT;
                if (bus.OUT_DAT_LST) last_lst_edge = cyc + 1;
            end
            if (bus.WTOE_DAT_VLD) checkOutput("wtoe_rdy_when_vld", 32'(bus.WTOE_DAT_RDY), 32'd1);
        end
    end

    // WRAM bank model: data appears in the cycle after the address handshake.
    initial begin
        logic       dat_fire;
        logic [DW:0] w;
        bus.WTOE_DAT_VLD = 1'b0;
        bus.WTOE_DAT_LST = 1'b0;
        bus.WTOE_DAT_DAT = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) wram_pend.delete();
            else if (bus.ETOW_ADD_VLD && bus.ETOW_ADD_RDY)
                wram_pend.push_back({bus.ETOW_ADD_LST, wramData(bus.ETOW_ADD_ADD)});
            dat_fire = bus.WTOE_DAT_VLD & bus.WTOE_DAT_RDY;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                wram_pend.delete();
                bus.WTOE_DAT_VLD = 1'b0;
            end else begin
                if (dat_fire) bus.WTOE_DAT_VLD = 1'b0;
                if (!bus.WTOE_DAT_VLD && wram_pend.size() > 0) begin
                    w = wram_pend.pop_front();
                    bus.WTOE_DAT_LST = w[DW];
                    bus.WTOE_DAT_DAT = w[DW-1:0];
                    bus.WTOE_DAT_VLD = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  ie;
        bit  hit;
        rst_n            = 1'b0;
        bus.CFG_INFO_VLD = 1'b0;
        bus.CFG_BASE_ADD = '0;
        bus.CFG_ADD_STP  = '0;
        bus.CFG_DAT_LEN  = '0;
        bus.ETOW_ADD_RDY = 1'b1;
        bus.OUT_DAT_RDY  = 1'b1;
        last_lst_edge    = 0;
        last_out_dat     = '0;
        clearStats();
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single word");
        clearStats();
        applyStimulus(13'h010, 13'd1, 13'd0, 1'b0);
        waitIdle(ie);
        checkOutput("t1_out_cnt",     32'(out_cnt), 32'd1);
        checkOutput("t1_addr",        32'(addr_log[0]), 32'h010);
        checkOutput("t1_dat_literal", 32'(last_out_dat), 32'hA5);
        checkOutput("t1_out_latency", 32'(first_out_edge), 32'(first_addr_edge + 2));
        checkOutput("t1_idle_edge",   32'(ie), 32'(last_lst_edge));

        $display("[TB] stride and wrap");
        clearStats();
        applyStimulus(13'h1FFE, 13'd3, 13'd3, 1'b0);
        waitIdle(ie);
        checkOutput("t2_addr_cnt", 32'(addr_cnt), 32'd4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++)
            checkOutput("t2_wrap_addr", 32'(addr_log[i]), 32'(wrap_exp[i]));

        $display("[TB] consumer stall");
        clearStats();
        bus.OUT_DAT_RDY = 1'b0;
        applyStimulus(13'h0200, 13'd5, 13'd9, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("t3_addr_cnt_stalled", 32'(addr_cnt), 32'd4);
        checkOutput("t3_etow_vld_low",     32'(bus.ETOW_ADD_VLD), 32'd0);
        bus.OUT_DAT_RDY = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t3_etow_vld_after_pop", 32'(bus.ETOW_ADD_VLD), 32'd1);
        waitIdle(ie);
        checkOutput("t3_out_cnt", 32'(out_cnt), 32'd10);

        $display("[TB] full throughput");
        clearStats();
        applyStimulus(13'h0300, 13'd1, 13'd15, 1'b0);
        waitIdle(ie);
        checkOutput("t4_addr_cnt",  32'(addr_cnt), 32'd16);
        checkOutput("t4_addr_span", 32'(last_addr_edge - first_addr_edge), 32'd15);
        checkOutput("t4_out_cnt",   32'(out_cnt), 32'd16);
        checkOutput("t4_out_span",  32'(last_out_edge - first_out_edge), 32'd15);

        $display("[TB] reset mid-fetch");
        clearStats();
        applyStimulus(13'h0040, 13'd2, 13'd7, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (addr_cnt >= 3) hit = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        checkOutput("t5_third_addr_seen", 32'(hit), 32'd1);
        rst_n = 1'b0;
        #1;
        checkResetValues("t5");
        exp_addr_q.delete();
        exp_out_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("t5_idle_after_release", 32'(bus.IS_IDLE), 32'd1);
        @(posedge clk);
        #1;
        clearStats();
        applyStimulus(13'h0100, 13'd1, 13'd1, 1'b0);
        waitIdle(ie);
        checkOutput("t5_new_out_cnt", 32'(out_cnt), 32'd2);

        $display("[TB] back-to-back");
        clearStats();
        applyStimulus(13'h0500, 13'd1, 13'd2, 1'b1);
        applyStimulus(13'h0600, 13'd2, 13'd1, 1'b0);
        checkOutput("t6_accept_edge",   32'(accept_edge), 32'(last_lst_edge + 1));
        checkOutput("t6_no_early_addr", 32'(addr_cnt), 32'd3);
        waitIdle(ie);
        checkOutput("t6_out_cnt", 32'(out_cnt), 32'd5);

        checkOutput("exp_addr_drained", 32'(exp_addr_q.size()), 32'd0);
        checkOutput("exp_out_drained",  32'(exp_out_q.size()),  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
